// File: rtl/cmp_pkg.sv
// Shared definitions for the streaming comparator: flag bit positions and
// the relation encoding used to pick which flag drives the match counter.
package cmp_pkg;

    localparam int FLAG_W  = 6;
    localparam int FLAG_EQ = 5;
    localparam int FLAG_NE = 4;
    localparam int FLAG_GT = 3;
    localparam int FLAG_LT = 2;
    localparam int FLAG_GE = 1;
    localparam int FLAG_LE = 0;

    typedef enum logic [2:0] {
        REL_LE   = 3'd0,
        REL_GE   = 3'd1,
        REL_LT   = 3'd2,
        REL_GT   = 3'd3,
        REL_NE   = 3'd4,
        REL_EQ   = 3'd5,
        REL_NONE = 3'd6
    } rel_e;

endpackage

// File: rtl/cmp_stream_if.sv
// Operand/result stream of the comparator with valid/ready on both sides.
interface cmp_stream_if
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              signed_mode;
    logic              out_valid;
    logic              out_ready;
    logic [FLAG_W-1:0] flags;
    logic              match;

    modport master (
        output in_valid, a, b, signed_mode, out_ready,
        input  in_ready, out_valid, flags, match
    );

    modport slave (
        input  in_valid, a, b, signed_mode, out_ready,
        output in_ready, out_valid, flags, match
    );
endinterface

// File: rtl/cmp_core.sv
// Combinational magnitude compare producing the six relation flags.
module cmp_core
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              signed_mode,
    output logic [FLAG_W-1:0] flags
);
    logic signed [WIDTH:0] a_ext;
    logic signed [WIDTH:0] b_ext;
    logic                  eq;
    logic                  gt;
    logic                  lt;

    // One extra bit lets a single signed compare serve both modes.
    always_comb begin
        a_ext = {signed_mode & a[WIDTH-1], a};
        b_ext = {signed_mode & b[WIDTH-1], b};
        eq    = (a == b);
        gt    = (a_ext > b_ext);
        lt    = (a_ext < b_ext);
        flags          = '0;
        flags[FLAG_EQ] = eq;
        flags[FLAG_NE] = !eq;
        flags[FLAG_GT] = gt;
        flags[FLAG_LT] = lt;
        flags[FLAG_GE] = gt | eq;
        flags[FLAG_LE] = lt | eq;
    end
endmodule

// File: rtl/cmp_stream.sv
// Two-stage streaming comparator with handshake and a saturating counter of
// results that satisfy the selected relation.
module cmp_stream
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    cmp_stream_if.slave      bus,
    input  logic [2:0]       sel,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] match_cnt
);
    logic              vld_p1_q, vld_p1_d;
    logic [WIDTH-1:0]  a_p1_q, a_p1_d;
    logic [WIDTH-1:0]  b_p1_q, b_p1_d;
    logic              sm_p1_q, sm_p1_d;
    logic              vld_p2_q, vld_p2_d;
    logic [FLAG_W-1:0] flags_p2_q, flags_p2_d;
    logic [CNT_W-1:0]  match_cnt_q, match_cnt_d;
    logic [FLAG_W-1:0] core_flags;
    logic              adv_p1, adv_p2, in_xfer, out_xfer, match;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic rel_match(input logic [FLAG_W-1:0] f, input logic [2:0] s);
        case (s)
            REL_LE:  return f[FLAG_LE];
            REL_GE:  return f[FLAG_GE];
            REL_LT:  return f[FLAG_LT];
            REL_GT:  return f[FLAG_GT];
            REL_NE:  return f[FLAG_NE];
            REL_EQ:  return f[FLAG_EQ];
            default: return 1'b0;
        endcase
    endfunction

    cmp_core #(.WIDTH(WIDTH)) u_core (
        .a           (a_p1_q),
        .b           (b_p1_q),
        .signed_mode (sm_p1_q),
        .flags       (core_flags)
    );

    always_comb begin
        adv_p2   = !vld_p2_q || bus.out_ready;
        adv_p1   = adv_p2 || !vld_p1_q;
        in_xfer  = bus.in_valid && adv_p1;
        out_xfer = vld_p2_q && bus.out_ready;

        // Stage 1: capture operands
        vld_p1_d = adv_p1 ? bus.in_valid : vld_p1_q;
        a_p1_d   = in_xfer ? bus.a : a_p1_q;
        b_p1_d   = in_xfer ? bus.b : b_p1_q;
        sm_p1_d  = in_xfer ? bus.signed_mode : sm_p1_q;

        // Stage 2: capture flags
        vld_p2_d   = adv_p2 ? vld_p1_q : vld_p2_q;
        flags_p2_d = (adv_p2 && vld_p1_q) ? core_flags : flags_p2_q;

        match = rel_match(flags_p2_q, sel);
        if (cnt_clr)
            match_cnt_d = '0;
        else if (out_xfer && match)
            match_cnt_d = sat_inc(match_cnt_q);
        else
            match_cnt_d = match_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            flags_p2_q  <= '0;
            match_cnt_q <= '0;
        end else begin
            vld_p1_q    <= vld_p1_d;
            vld_p2_q    <= vld_p2_d;
            flags_p2_q  <= flags_p2_d;
            match_cnt_q <= match_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        a_p1_q  <= a_p1_d;
        b_p1_q  <= b_p1_d;
        sm_p1_q <= sm_p1_d;
    end

    assign bus.in_ready  = adv_p1;
    assign bus.out_valid = vld_p2_q;
    assign bus.flags     = flags_p2_q;
    assign bus.match     = match;
    assign match_cnt     = match_cnt_q;
endmodule

// File: tb/tb_cmp_stream.sv
// Randomised and directed bench for cmp_stream against a queue-based
// reference model of the comparator stream and match counter.
module tb_cmp_stream;
    localparam int WIDTH   = 8;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [2:0]       sel;
    logic             cnt_clr;
    logic [CNT_W-1:0] match_cnt;

    cmp_stream_if #(.WIDTH(WIDTH)) bus ();

    cmp_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .sel       (sel),
        .cnt_clr   (cnt_clr),
        .match_cnt (match_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] f;
        int         stamp;
    } exp_t;

    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    int   n_out = 0;
    bit   mon_en = 0;
    bit   saw_stall = 0;
    bit   prev_hold = 0;
    logic [5:0] prev_flags;
    exp_t q[$];
    int   cnt_m = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // Relation flags straight from the numeric values of the operands.
    function automatic logic [5:0] model_flags(input logic [7:0] x, input logic [7:0] y, input logic sm);
        int vx, vy;
        bit eq, gt, lt;
        vx = sm ? int'($signed(x)) : int'(x);
        vy = sm ? int'($signed(y)) : int'(y);
        eq = (vx == vy);
        gt = (vx > vy);
        lt = (vx < vy);
        return {eq, !eq, gt, lt, gt || eq, lt || eq};
    endfunction

    function automatic logic model_match(input logic [5:0] f, input logic [2:0] s);
        if (s > 3'd5) return 1'b0;
        return f[s];
    endfunction

    function automatic logic [7:0] rand_op();
        case ($urandom_range(0, 5))
            0:       return 8'h00;
            1:       return 8'hFF;
            2:       return 8'h80;
            3:       return 8'h7F;
            default: return 8'($urandom);
        endcase
    endfunction

    bit   exp_ov, in_x, out_x;
    exp_t e;

    always @(negedge clk) begin
        if (mon_en) begin
            exp_ov = (q.size() > 0) && (cyc >= q[0].stamp);
            chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
            chk("in_ready", 32'(bus.in_ready), 32'((q.size() < 2) || bus.out_ready));
            chk("match_cnt", 32'(match_cnt), 32'(cnt_m));
            if (bus.out_valid && q.size() > 0) begin
                chk("flags", 32'(bus.flags), 32'(q[0].f));
                chk("match", 32'(bus.match), 32'(model_match(q[0].f, sel)));
            end
            if (prev_hold) begin
                chk("hold_valid", 32'(bus.out_valid), 32'(1));
                chk("hold_flags", 32'(bus.flags), 32'(prev_flags));
            end
            if (!bus.in_ready) saw_stall = 1;

            in_x  = bus.in_valid && bus.in_ready;
            out_x = bus.out_valid && bus.out_ready;
            if (rst) begin
                q.delete();
                cnt_m     = 0;
                prev_hold = 0;
            end else begin
                if (cnt_clr) cnt_m = 0;
                else if (out_x && q.size() > 0 && model_match(q[0].f, sel))
                    cnt_m = (cnt_m < CNT_MAX) ? cnt_m + 1 : CNT_MAX;
                if (out_x && q.size() > 0) begin
                    void'(q.pop_front());
                    n_out++;
                end
                if (in_x) begin
                    e.f     = model_flags(bus.a, bus.b, bus.signed_mode);
                    e.stamp = cyc + 2;
                    q.push_back(e);
                end
                prev_hold  = bus.out_valid && !bus.out_ready;
                prev_flags = bus.flags;
            end
        end
    end

    task automatic single(input logic [7:0] x, input logic [7:0] y, input logic sm,
                          input logic [5:0] expf, input string name);
        @(posedge clk); #1;
        bus.a = x; bus.b = y; bus.signed_mode = sm;
        bus.in_valid = 1; bus.out_ready = 1;
        @(posedge clk); #1;
        bus.in_valid = 0;
        @(negedge clk);
        chk({name, "_lat1"}, 32'(bus.out_valid), 32'(0));
        @(negedge clk);
        chk({name, "_lat2"}, 32'(bus.out_valid), 32'(1));
        chk(name, 32'(bus.flags), 32'(expf));
    endtask

    task automatic push_pair(input logic [7:0] x, input logic [7:0] y, input logic sm);
        bus.a = x; bus.b = y; bus.signed_mode = sm; bus.in_valid = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk); #1;
                return;
            end
        end
        fail_now("push_timeout");
    endtask

    task automatic wait_idle();
        bus.in_valid = 0; bus.out_ready = 1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !bus.out_valid) return;
        end
        fail_now("drain_timeout");
    endtask

    initial begin
        int outs0;
        bus.in_valid = 0; bus.a = 0; bus.b = 0; bus.signed_mode = 0;
        bus.out_ready = 1; sel = 3'd0; cnt_clr = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0; mon_en = 1;
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("rst_flags", 32'(bus.flags), 32'(0));
        chk("rst_match", 32'(bus.match), 32'(0));
        chk("rst_cnt", 32'(match_cnt), 32'(0));
        chk("rst_in_ready", 32'(bus.in_ready), 32'(1));

        single(8'hFF, 8'h01, 1'b0, 6'b011010, "ff_01_u");
        single(8'hFF, 8'h01, 1'b1, 6'b010101, "ff_01_s");
        single(8'hA5, 8'hA5, 1'b0, 6'b100011, "a5_eq_u");
        single(8'hA5, 8'hA5, 1'b1, 6'b100011, "a5_eq_s");
        single(8'h80, 8'h7F, 1'b1, 6'b010101, "80_7f_s");
        single(8'h80, 8'h7F, 1'b0, 6'b011010, "80_7f_u");
        single(8'hFF, 8'hFF, 1'b1, 6'b100011, "ff_eq_s");
        single(8'hFF, 8'hFF, 1'b0, 6'b100011, "ff_eq_u");
        wait_idle();

        // Back-to-back stream with a 3-cycle downstream stall
        saw_stall = 0;
        outs0 = n_out;
        @(posedge clk); #1;
        fork
            begin
                for (int i = 0; i < 5; i++)
                    push_pair(8'(16 + 7 * i), 8'(40 - 5 * i), 1'(i % 2));
                bus.in_valid = 0;
            end
            begin
                bus.out_ready = 1;
                repeat (2) @(posedge clk);
                #1 bus.out_ready = 0;
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1;
            end
        join
        wait_idle();
        chk("stream_stall_seen", 32'(saw_stall), 32'(1));
        chk("stream_count", 32'(n_out - outs0), 32'(5));

        // Counter saturation on lt, then clear beating a matching transfer
        @(posedge clk); #1;
        sel = 3'd2; cnt_clr = 1;
        @(posedge clk); #1 cnt_clr = 0;
        @(negedge clk);
        chk("cnt_cleared", 32'(match_cnt), 32'(0));
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) begin
            logic [7:0] x;
            x = 8'($urandom_range(0, 200));
            push_pair(x, x + 8'($urandom_range(1, 55)), 1'b0);
        end
        wait_idle();
        chk("cnt_sat", 32'(match_cnt), 32'(15));
        @(posedge clk); #1;
        push_pair(8'd3, 8'd9, 1'b0);
        bus.in_valid = 0;
        @(posedge clk); #1 cnt_clr = 1;
        @(negedge clk);
        chk("clr_xfer_valid", 32'(bus.out_valid), 32'(1));
        @(posedge clk); #1 cnt_clr = 0;
        @(negedge clk);
        chk("clr_priority", 32'(match_cnt), 32'(0));

        // sel=6 never matches
        @(posedge clk); #1;
        sel = 3'd6;
        push_pair(8'h05, 8'h05, 1'b0);
        push_pair(8'h01, 8'h02, 1'b0);
        push_pair(8'h02, 8'h01, 1'b1);
        push_pair(8'h80, 8'h7F, 1'b1);
        wait_idle();
        chk("sel6_cnt", 32'(match_cnt), 32'(0));

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            bus.in_valid    = ($urandom_range(0, 3) != 0);
            bus.a           = rand_op();
            bus.b           = ($urandom_range(0, 4) == 0) ? bus.a : rand_op();
            bus.signed_mode = 1'($urandom_range(0, 1));
            bus.out_ready   = ($urandom_range(0, 2) != 0);
            cnt_clr         = ($urandom_range(0, 49) == 0);
            if (i % 50 == 0) sel = 3'($urandom_range(0, 7));
        end
        @(posedge clk); #1 cnt_clr = 0;
        wait_idle();

        // Reset with two pairs in flight
        @(posedge clk); #1;
        sel = 3'd5;
        push_pair(8'h07, 8'h07, 1'b0);
        wait_idle();
        @(posedge clk); #1;
        bus.out_ready = 0;
        push_pair(8'h01, 8'h02, 1'b0);
        push_pair(8'h03, 8'h04, 1'b1);
        bus.in_valid = 0;
        rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("rst_flight_valid", 32'(bus.out_valid), 32'(0));
        chk("rst_flight_cnt", 32'(match_cnt), 32'(0));
        bus.out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_flush", 32'(bus.out_valid), 32'(0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/cmp_stream.md
Name: cmp_stream

Overview:
- Streaming, parametrised magnitude comparator for pairs of operands A/B of width WIDTH.
- Supports signed and unsigned compare, selected per transaction.
- Two-stage register pipeline with valid/ready handshake on both sides.
- Produces the six-flag relation vector per pair, plus a saturating counter of pairs that satisfy a selected relation. Intended for threshold/statistics paths in datapath blocks.

Parameters:
- WIDTH, 8, operand width in bits (>= 2).
- CNT_W, 16, match counter width in bits (>= 1).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept a pair this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- signed_mode  in  1  1 = two's-complement compare, 0 = unsigned; sampled with a/b.
- sel  in  3  relation counted by match_cnt; quasi-static.
- cnt_clr  in  1  synchronous clear of match_cnt.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- flags  out  6  [5] eq, [4] ne, [3] gt, [2] lt, [1] ge, [0] le.
- match  out  1  flags[sel] of the current result (0 when sel is 6 or 7).
- match_cnt  out  CNT_W  number of accepted results with match = 1, saturating.

Behaviour:
- Reset state: out_valid=0, flags=0, match=0, match_cnt=0, both pipeline valids=0. in_ready=1 in the cycle after reset deasserts.
- Reset mid-transfer discards all in-flight pairs; no partial output.
- Input transfer: when in_valid && in_ready. Output transfer: when out_valid && out_ready.
- Stage 1 registers a, b and signed_mode. Stage 2 registers flags computed from stage-1 contents.
- Latency: 2 cycles from input transfer to out_valid when there is no backpressure.
- Throughput: 1 pair per cycle.
- Stall rule: stage 2 advances when !s2_valid || out_ready. Stage 1 advances when stage 2 advances or !s1_valid.
- in_ready = !s1_valid || stage-2 advance. in_ready must not depend combinationally on in_valid.
- While out_valid=1 and out_ready=0, flags, match and out_valid hold stable. No pair is lost or duplicated under any ready pattern.
- Compare rules:
  - Signed mode interprets both operands as two's complement; unsigned mode as plain binary.
  - Exactly one of eq/gt/lt is set.
  - ne = !eq, ge = gt|eq, le = lt|eq.
- sel mapping: 0→le, 1→ge, 2→lt, 3→gt, 4→ne, 5→eq, 6/7→never match.
- sel is read at stage-2 output, i.e. match reflects the current sel against the held flags.
- match_cnt:
  - Increments by 1 on each output transfer with match=1.
  - Saturates at all-ones; no wrap.
  - cnt_clr sets it to 0 and has priority: a transfer in the same cycle is not counted.
  - Not affected by stalls.
- Extremes: a = b = all-ones gives flags=100011 in either mode. In signed mode, most-negative vs most-positive gives lt.

Decomposition:
- Shared package cmp_pkg:
  - Flag bit index constants FLAG_EQ=5, FLAG_NE=4, FLAG_GT=3, FLAG_LT=2, FLAG_GE=1, FLAG_LE=0.
  - Relation select enum for sel (REL_LE..REL_EQ, REL_NONE).
- One combinational sub-module, cmp_core (param WIDTH; inputs a, b, signed_mode; output flags[5:0]). It is the same core other blocks reuse.
- Pipeline, handshake and counter live in cmp_stream.

Test Plan (WIDTH=8, CNT_W=4):
- Reset then a=FF, b=01, signed_mode=0, out_ready=1 -> 2 cycles later out_valid=1, flags=011010. Repeat with signed_mode=1 -> flags=010101.
- a=b=A5 in both modes -> flags=100011. a=80, b=7F, signed -> flags=010101; unsigned -> flags=011010.
- Back-to-back stream of 5 pairs, out_ready low for 3 cycles mid-stream -> in_ready drops; all 5 results appear in order, unchanged while stalled, none duplicated.
- sel=2 (lt), 20 accepted results all lt -> match_cnt saturates at F and holds. Then cnt_clr=1 in the same cycle as a matching transfer -> match_cnt=0 next cycle.
- sel=6, 4 transfers -> match=0 and match_cnt stays 0.
- Assert rst with 2 pairs in flight -> next cycle out_valid=0 and match_cnt=0; the pairs never emerge.
